alu_op_issuer: RTL

Command-issuing front end for the 32-bit ALU. Accepts queued operations (command code plus two operands) on a valid/ready handshake and drives them onto the ALU's 3-bit command bus, which the ALU's own control lookup decodes into mux select and invert. After a fixed settle interval it registers the ALU result and flags, then returns them on a second valid/ready handshake. It sits between the test/CPU sequencing logic and the combinational ALU.

---
 rtl/alu_op_issuer.sv | 232 +++++++++++++++++++++++
 1 files changed

// File: rtl/alu_op_issuer.sv
// Command FIFO plus settle/hold sequencer that drives the combinational ALU and returns its result.
// Optional feature: define ALU_ISSUE_CHECK_EN to compare the ALU result against a built-in model.
module alu_op_issuer #(
    parameter int WIDTH         = 32,
    parameter int DEPTH         = 4,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_cmd,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic [2:0]       alu_command,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_carryout,
    input  logic             alu_zero,
    input  logic             alu_overflow,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [2:0]       out_flags,
    output logic [2:0]       out_cmd,
    output logic             out_mismatch,
    output logic             busy
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int EW = 2 * WIDTH + 3;
    localparam logic [CW-1:0] CNT_LOAD = CW'(SETTLE_CYCLES - 1);
    localparam logic [AW:0]   COUNT_FULL = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_HOLD   = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [EW-1:0]    r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic [CW-1:0]    r_cnt;
    logic [2:0]       r_alu_command;
    logic [WIDTH-1:0] r_alu_a;
    logic [WIDTH-1:0] r_alu_b;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_result;
    logic [2:0]       r_out_flags;
    logic [2:0]       r_out_cmd;
    logic             w_push;
    logic             w_pop;
    logic             w_empty;
    logic             w_capture;
    logic             w_release;
    logic             w_cnt_dec;
    logic [EW-1:0]    w_head;

    assign w_empty  = (r_count == {(AW + 1){1'b0}});
    assign in_ready = (r_count != COUNT_FULL);
    assign w_push   = in_valid & in_ready;
    assign w_head   = r_mem[r_rd_ptr];

    // FIFO storage; entries are {cmd, a, b}
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {in_cmd, in_a, in_b};
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= {AW{1'b0}};
            r_rd_ptr <= {AW{1'b0}};
            r_count  <= {(AW + 1){1'b0}};
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW + 1)'(1);
                2'b01:   r_count <= r_count - (AW + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Sequencer state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Sequencer next state and datapath strobes
    always_comb begin
        w_state_next = r_state;
        w_pop        = 1'b0;
        w_capture    = 1'b0;
        w_release    = 1'b0;
        w_cnt_dec    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_pop        = 1'b1;
                    w_state_next = S_SETTLE;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            S_SETTLE: begin
                if (r_cnt == {CW{1'b0}}) begin
                    w_capture    = 1'b1;
                    w_state_next = S_HOLD;
                end else begin
                    w_cnt_dec    = 1'b1;
                end
            end
            S_HOLD: begin
                if (out_ready) begin
                    w_release = 1'b1;
                    // Back-to-back: the next command issues on the same edge as the handshake
                    if (!w_empty) begin
                        w_pop        = 1'b1;
                        w_state_next = S_SETTLE;
                    end else begin
                        w_state_next = S_IDLE;
                    end
                end else begin
                    w_state_next = S_HOLD;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // ALU drive registers and settle counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt         <= {CW{1'b0}};
            r_alu_command <= 3'd0;
            r_alu_a       <= {WIDTH{1'b0}};
            r_alu_b       <= {WIDTH{1'b0}};
        end else if (w_pop) begin
            r_cnt         <= CNT_LOAD;
            r_alu_command <= w_head[EW-1 -: 3];
            r_alu_a       <= w_head[2*WIDTH-1 -: WIDTH];
            r_alu_b       <= w_head[WIDTH-1:0];
        end else if (w_cnt_dec) begin
            r_cnt <= r_cnt - CW'(1);
        end
    end

    // Result capture and output handshake
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out_valid  <= 1'b0;
            r_out_result <= {WIDTH{1'b0}};
            r_out_flags  <= 3'd0;
            r_out_cmd    <= 3'd0;
        end else if (w_capture) begin
            r_out_valid  <= 1'b1;
            r_out_result <= alu_result;
            r_out_flags  <= {alu_carryout, alu_zero, alu_overflow};
            r_out_cmd    <= r_alu_command;
        end else if (w_release) begin
            r_out_valid <= 1'b0;
        end
    end

`ifdef ALU_ISSUE_CHECK_EN
    logic r_mismatch;

    function automatic logic [WIDTH-1:0] expected_result(
        input logic [2:0]       cmd,
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b
    );
        logic [WIDTH-1:0] res;
        case (cmd)
            3'd0:    res = a + b;
            3'd1:    res = a - b;
            3'd2:    res = a ^ b;
            3'd3:    res = ($signed(a) < $signed(b)) ? {{(WIDTH-1){1'b0}}, 1'b1} : {WIDTH{1'b0}};
            3'd4:    res = a & b;
            3'd5:    res = ~(a & b);
            3'd6:    res = ~(a | b);
            default: res = a | b;
        endcase
        return res;
    endfunction

    // Self-check flag travels with the captured result
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mismatch <= 1'b0;
        end else if (w_capture) begin
            r_mismatch <= (alu_result != expected_result(r_alu_command, r_alu_a, r_alu_b));
        end else if (w_release) begin
            r_mismatch <= 1'b0;
        end
    end

    assign out_mismatch = r_mismatch;
`else
    assign out_mismatch = 1'b0;
`endif

    assign alu_command = r_alu_command;
    assign alu_a       = r_alu_a;
    assign alu_b       = r_alu_b;
    assign out_valid   = r_out_valid;
    assign out_result  = r_out_result;
    assign out_flags   = r_out_flags;
    assign out_cmd     = r_out_cmd;
    assign busy        = (r_state != S_IDLE) || !w_empty;

endmodule
